// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes one MIPS instruction into ALU controls and operands,
// and holds them in a stallable, flushable ID/EX register with saturating issue counters.
module alu_issue_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [31:0]      id_instr,
  input  logic [31:0]      id_rs_data,
  input  logic [31:0]      id_rt_data,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [4:0]       ex_alu_op,
  output logic [31:0]      ex_arg1,
  output logic [31:0]      ex_arg2,
  output logic [4:0]       ex_shamt,
  output logic [31:0]      ex_store_data,
  output logic [4:0]       ex_wr_reg,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_branch,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rt_field;
  logic [4:0]  rd_field;
  logic [31:0] imm_se;
  logic [31:0] imm_ze;
  logic        rs_field_unused;
  logic        transfer;

  assign op       = id_instr[31:26];
  assign funct    = id_instr[5:0];
  assign rt_field = id_instr[20:16];
  assign rd_field = id_instr[15:11];
  assign imm_se   = {{16{id_instr[15]}}, id_instr[15:0]};
  assign imm_ze   = {16'h0000, id_instr[15:0]};
  // The rs index is consumed by the register file upstream; only its data arrives here.
  assign rs_field_unused = ^id_instr[25:21];

  logic [4:0]  dec_alu_op;
  logic [31:0] dec_arg1;
  logic [31:0] dec_arg2;
  logic [4:0]  dec_wr_reg;
  logic        dec_reg_write;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic        dec_branch;
  logic        dec_illegal;

  always_comb begin
    dec_alu_op    = 5'b00000;
    dec_arg1      = id_rs_data;
    dec_arg2      = id_rt_data;
    dec_wr_reg    = rt_field;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_branch    = 1'b0;
    dec_illegal   = 1'b0;
    case (op)
      6'h00: begin
        dec_wr_reg    = rd_field;
        dec_reg_write = 1'b1;
        case (funct)
          6'h20, 6'h21: dec_alu_op = 5'b00000;
          6'h22, 6'h23: dec_alu_op = 5'b00001;
          6'h24:        dec_alu_op = 5'b00010;
          6'h25:        dec_alu_op = 5'b00011;
          6'h27:        dec_alu_op = 5'b00100;
          6'h2A:        dec_alu_op = 5'b01000;
          // Shifts take their amount from shamt, so arg1 is unused and zeroed.
          6'h00: begin dec_alu_op = 5'b00101; dec_arg1 = '0; end
          6'h02: begin dec_alu_op = 5'b00110; dec_arg1 = '0; end
          6'h03: begin dec_alu_op = 5'b00111; dec_arg1 = '0; end
          default: begin
            dec_illegal   = 1'b1;
            dec_reg_write = 1'b0;
          end
        endcase
      end
      6'h08, 6'h09: begin dec_alu_op = 5'b00000; dec_arg2 = imm_se; dec_reg_write = 1'b1; end
      6'h0C:        begin dec_alu_op = 5'b00010; dec_arg2 = imm_ze; dec_reg_write = 1'b1; end
      6'h0D:        begin dec_alu_op = 5'b00011; dec_arg2 = imm_ze; dec_reg_write = 1'b1; end
      6'h0A:        begin dec_alu_op = 5'b01000; dec_arg2 = imm_se; dec_reg_write = 1'b1; end
      6'h0F:        begin dec_alu_op = 5'b01001; dec_arg2 = imm_ze; dec_reg_write = 1'b1; end
      6'h23: begin
        dec_alu_op    = 5'b01110;
        dec_arg2      = imm_se;
        dec_reg_write = 1'b1;
        dec_mem_read  = 1'b1;
      end
      6'h2B: begin
        dec_alu_op    = 5'b01110;
        dec_arg2      = imm_se;
        dec_mem_write = 1'b1;
      end
      6'h04: begin dec_alu_op = 5'b01101; dec_branch = 1'b1; end
      6'h05: begin dec_alu_op = 5'b01010; dec_branch = 1'b1; end
      6'h07: begin dec_alu_op = 5'b01011; dec_branch = 1'b1; end
      6'h01: begin
        if (rt_field == 5'd1) begin
          dec_alu_op = 5'b01100;
          dec_branch = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_wr_reg == 5'd0) dec_reg_write = 1'b0;
  end

  logic             ex_valid_reg;
  logic [4:0]       ex_alu_op_reg;
  logic [31:0]      ex_arg1_reg;
  logic [31:0]      ex_arg2_reg;
  logic [4:0]       ex_shamt_reg;
  logic [31:0]      ex_store_data_reg;
  logic [4:0]       ex_wr_reg_reg;
  logic             ex_reg_write_reg;
  logic             ex_mem_read_reg;
  logic             ex_mem_write_reg;
  logic             ex_branch_reg;
  logic             ex_illegal_reg;
  logic [CNT_W-1:0] issue_cnt_reg;
  logic [CNT_W-1:0] illegal_cnt_reg;

  assign id_ready = !ex_valid_reg || ex_ready;
  assign transfer = id_valid && id_ready && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_reg      <= 1'b0;
      ex_alu_op_reg     <= '0;
      ex_arg1_reg       <= '0;
      ex_arg2_reg       <= '0;
      ex_shamt_reg      <= '0;
      ex_store_data_reg <= '0;
      ex_wr_reg_reg     <= '0;
      ex_reg_write_reg  <= 1'b0;
      ex_mem_read_reg   <= 1'b0;
      ex_mem_write_reg  <= 1'b0;
      ex_branch_reg     <= 1'b0;
      ex_illegal_reg    <= 1'b0;
      issue_cnt_reg     <= '0;
      illegal_cnt_reg   <= '0;
    end else begin
      if (flush) begin
        ex_valid_reg <= 1'b0;
      end else if (transfer) begin
        ex_valid_reg      <= 1'b1;
        ex_alu_op_reg     <= dec_alu_op;
        ex_arg1_reg       <= dec_arg1;
        ex_arg2_reg       <= dec_arg2;
        ex_shamt_reg      <= id_instr[10:6];
        ex_store_data_reg <= id_rt_data;
        ex_wr_reg_reg     <= dec_wr_reg;
        ex_reg_write_reg  <= dec_reg_write;
        ex_mem_read_reg   <= dec_mem_read;
        ex_mem_write_reg  <= dec_mem_write;
        ex_branch_reg     <= dec_branch;
        ex_illegal_reg    <= dec_illegal;
      end else if (ex_ready) begin
        ex_valid_reg <= 1'b0;
      end
      if (transfer) begin
        if (issue_cnt_reg != {CNT_W{1'b1}}) issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
        if (dec_illegal && illegal_cnt_reg != {CNT_W{1'b1}})
          illegal_cnt_reg <= illegal_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign ex_valid      = ex_valid_reg;
  assign ex_alu_op     = ex_alu_op_reg;
  assign ex_arg1       = ex_arg1_reg;
  assign ex_arg2       = ex_arg2_reg;
  assign ex_shamt      = ex_shamt_reg;
  assign ex_store_data = ex_store_data_reg;
  assign ex_wr_reg     = ex_wr_reg_reg;
  assign ex_reg_write  = ex_reg_write_reg;
  assign ex_mem_read   = ex_mem_read_reg;
  assign ex_mem_write  = ex_mem_write_reg;
  assign ex_branch     = ex_branch_reg;
  assign ex_illegal    = ex_illegal_reg;
  assign issue_cnt     = issue_cnt_reg;
  assign illegal_cnt   = illegal_cnt_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios followed by random traffic, all checked
// against a mnemonic-level reference model of the ID/EX register.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset, id_valid, flush, ex_ready;
  logic [31:0] id_instr, id_rs_data, id_rt_data;

  logic        id_ready, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal;
  logic [4:0]  ex_alu_op, ex_shamt, ex_wr_reg;
  logic [31:0] ex_arg1, ex_arg2, ex_store_data;
  logic [15:0] issue_cnt, illegal_cnt;

  logic        s_id_ready, s_ex_valid, s_reg_write, s_mem_read, s_mem_write, s_branch, s_illegal;
  logic [4:0]  s_alu_op, s_shamt, s_wr_reg;
  logic [31:0] s_arg1, s_arg2, s_store_data;
  logic [1:0]  s_issue_cnt, s_illegal_cnt;

  always #5 clk = ~clk;

  alu_issue_stage #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_arg1(ex_arg1), .ex_arg2(ex_arg2),
    .ex_shamt(ex_shamt), .ex_store_data(ex_store_data), .ex_wr_reg(ex_wr_reg),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_illegal(ex_illegal), .issue_cnt(issue_cnt), .illegal_cnt(illegal_cnt)
  );

  // Narrow-counter instance fed the same stream, to observe saturation quickly.
  alu_issue_stage #(.CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(s_id_ready), .id_instr(id_instr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(s_ex_valid), .ex_alu_op(s_alu_op), .ex_arg1(s_arg1), .ex_arg2(s_arg2),
    .ex_shamt(s_shamt), .ex_store_data(s_store_data), .ex_wr_reg(s_wr_reg),
    .ex_reg_write(s_reg_write), .ex_mem_read(s_mem_read), .ex_mem_write(s_mem_write),
    .ex_branch(s_branch), .ex_illegal(s_illegal), .issue_cnt(s_issue_cnt), .illegal_cnt(s_illegal_cnt)
  );

  typedef struct packed {
    logic [4:0]  alu;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [4:0]  wr;
    logic [4:0]  shamt;
    logic [31:0] store;
    logic        rw, mr, mw, br, ill;
    logic        chk_args, chk_wr, chk_store;
  } dec_t;

  int   tests = 0;
  int   fails = 0;
  dec_t m_d;
  logic m_valid;
  int   m_issue, m_ill;

  logic [5:0] op_tab [13] = '{6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0A, 6'h0F,
                              6'h23, 6'h2B, 6'h04, 6'h05, 6'h07, 6'h01};
  logic [5:0] fn_tab [11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27,
                              6'h2A, 6'h00, 6'h02, 6'h03};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic string mnemonic(input logic [31:0] ins);
    if (ins[31:26] == 6'h00) begin
      case (ins[5:0])
        6'h20: return "add";  6'h21: return "addu"; 6'h22: return "sub";
        6'h23: return "subu"; 6'h24: return "and";  6'h25: return "or";
        6'h27: return "nor";  6'h2A: return "slt";  6'h00: return "sll";
        6'h02: return "srl";  6'h03: return "sra";
        default: return "bad";
      endcase
    end
    case (ins[31:26])
      6'h08: return "addi"; 6'h09: return "addiu"; 6'h0C: return "andi";
      6'h0D: return "ori";  6'h0A: return "slti";  6'h0F: return "lui";
      6'h23: return "lw";   6'h2B: return "sw";    6'h04: return "beq";
      6'h05: return "bne";  6'h07: return "bgtz";
      6'h01: return (ins[20:16] == 5'd1) ? "bgez" : "bad";
      default: return "bad";
    endcase
  endfunction

  function automatic dec_t ref_decode(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    dec_t        d;
    string       m;
    logic [31:0] se, ze;
    logic        rtype;
    m     = mnemonic(ins);
    se    = {{16{ins[15]}}, ins[15:0]};
    ze    = {16'h0000, ins[15:0]};
    rtype = (ins[31:26] == 6'h00) && (m != "bad");
    d       = '0;
    d.a1    = rs;
    d.a2    = rt;
    d.wr    = rtype ? ins[15:11] : ins[20:16];
    d.shamt = ins[10:6];
    d.store = rt;
    case (m)
      "add", "addu":   d.alu = 5'd0;
      "sub", "subu":   d.alu = 5'd1;
      "and":           d.alu = 5'd2;
      "or":            d.alu = 5'd3;
      "nor":           d.alu = 5'd4;
      "sll":           begin d.alu = 5'd5; d.a1 = 0; end
      "srl":           begin d.alu = 5'd6; d.a1 = 0; end
      "sra":           begin d.alu = 5'd7; d.a1 = 0; end
      "slt":           d.alu = 5'd8;
      "addi", "addiu": begin d.alu = 5'd0; d.a2 = se; end
      "andi":          begin d.alu = 5'd2; d.a2 = ze; end
      "ori":           begin d.alu = 5'd3; d.a2 = ze; end
      "slti":          begin d.alu = 5'd8; d.a2 = se; end
      "lui":           begin d.alu = 5'd9; d.a2 = ze; end
      "lw":            begin d.alu = 5'd14; d.a2 = se; d.mr = 1'b1; end
      "sw":            begin d.alu = 5'd14; d.a2 = se; d.mw = 1'b1; end
      "beq":           begin d.alu = 5'd13; d.br = 1'b1; end
      "bne":           begin d.alu = 5'd10; d.br = 1'b1; end
      "bgtz":          begin d.alu = 5'd11; d.br = 1'b1; end
      "bgez":          begin d.alu = 5'd12; d.br = 1'b1; end
      default:         d.ill = 1'b1;
    endcase
    d.rw = !d.ill && !d.br && !d.mw && (d.wr != 5'd0);
    d.chk_args  = !d.ill;
    d.chk_wr    = !d.ill && !d.br;
    d.chk_store = d.mw;
    return d;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 14);
    if (k < 13) w[31:26] = op_tab[k];
    if (w[31:26] == 6'h00 && $urandom_range(0, 7) != 0) w[5:0] = fn_tab[$urandom_range(0, 10)];
    if (w[31:26] == 6'h01 && $urandom_range(0, 1) == 1) w[20:16] = 5'd1;
    if ($urandom_range(0, 9) == 0) w[15:11] = 5'd0;
    if ($urandom_range(0, 9) == 0) w[20:16] = 5'd0;
    return w;
  endfunction

  // One clock: drive at the falling edge, update the model at the rising edge, compare 1 time unit later.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] rsd,
                      input logic [31:0] rtd, input logic fl, input logic er, input logic rst);
    logic rdy, xfer;
    reset = rst; id_valid = v; id_instr = ins; id_rs_data = rsd; id_rt_data = rtd;
    flush = fl; ex_ready = er;
    #1;
    rdy = !m_valid || er;
    check("id_ready", 32'(id_ready), 32'(rdy));
    @(posedge clk);
    xfer = v && rdy && !fl;
    if (rst) begin
      m_valid = 1'b0; m_d = '0; m_issue = 0; m_ill = 0;
      m_d.chk_args = 1'b1; m_d.chk_wr = 1'b1; m_d.chk_store = 1'b1;
    end else begin
      if (fl) m_valid = 1'b0;
      else if (xfer) begin m_valid = 1'b1; m_d = ref_decode(ins, rsd, rtd); end
      else if (er) m_valid = 1'b0;
      if (xfer) begin
        m_issue++;
        if (mnemonic(ins) == "bad") m_ill++;
      end
    end
    #1;
    check("ex_valid", 32'(ex_valid), 32'(m_valid));
    check("ex_alu_op", 32'(ex_alu_op), 32'(m_d.alu));
    check("ex_shamt", 32'(ex_shamt), 32'(m_d.shamt));
    check("ex_reg_write", 32'(ex_reg_write), 32'(m_d.rw));
    check("ex_mem_read", 32'(ex_mem_read), 32'(m_d.mr));
    check("ex_mem_write", 32'(ex_mem_write), 32'(m_d.mw));
    check("ex_branch", 32'(ex_branch), 32'(m_d.br));
    check("ex_illegal", 32'(ex_illegal), 32'(m_d.ill));
    if (m_d.chk_args) begin
      check("ex_arg1", ex_arg1, m_d.a1);
      check("ex_arg2", ex_arg2, m_d.a2);
    end
    if (m_d.chk_wr) check("ex_wr_reg", 32'(ex_wr_reg), 32'(m_d.wr));
    if (m_d.chk_store) check("ex_store_data", ex_store_data, m_d.store);
    check("issue_cnt", 32'(issue_cnt), 32'((m_issue > 65535) ? 65535 : m_issue));
    check("illegal_cnt", 32'(illegal_cnt), 32'((m_ill > 65535) ? 65535 : m_ill));
    check("s_issue_cnt", 32'(s_issue_cnt), 32'((m_issue > 3) ? 3 : m_issue));
    check("s_illegal_cnt", 32'(s_illegal_cnt), 32'((m_ill > 3) ? 3 : m_ill));
    check("s_ex_valid", 32'(s_ex_valid), 32'(m_valid));
    @(negedge clk);
  endtask

  initial begin
    int          cnt_before;
    logic [31:0] held_arg1, held_arg2;
    m_valid = 1'b0; m_d = '0; m_issue = 0; m_ill = 0;
    reset = 1'b1; id_valid = 1'b0; id_instr = '0; id_rs_data = '0; id_rt_data = '0;
    flush = 1'b0; ex_ready = 1'b0;
    @(negedge clk);

    // Reset state.
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    check("rst_id_ready", 32'(id_ready), 32'd1);
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_issue_cnt", 32'(issue_cnt), 32'd0);

    // add $3,$1,$2
    step(1'b1, 32'h00221820, 32'd5, 32'd7, 1'b0, 1'b1, 1'b0);
    check("add_op", 32'(ex_alu_op), 32'd0);
    check("add_arg1", ex_arg1, 32'd5);
    check("add_arg2", ex_arg2, 32'd7);
    check("add_wr_reg", 32'(ex_wr_reg), 32'd3);
    check("add_reg_write", 32'(ex_reg_write), 32'd1);
    check("add_issue_cnt", 32'(issue_cnt), 32'd1);

    // addi $2,$1,-4 and ori $2,$1,0xFFFC: sign vs zero extension.
    step(1'b1, 32'h2022FFFC, 32'd9, 32'd1, 1'b0, 1'b1, 1'b0);
    check("addi_arg2", ex_arg2, 32'hFFFFFFFC);
    step(1'b1, 32'h3422FFFC, 32'd9, 32'd1, 1'b0, 1'b1, 1'b0);
    check("ori_arg2", ex_arg2, 32'h0000FFFC);
    check("ori_op", 32'(ex_alu_op), 32'd3);

    // Stall for 3 cycles with a new instruction waiting, then release.
    step(1'b1, 32'h00221822, 32'h11, 32'h22, 1'b0, 1'b1, 1'b0);
    held_arg1 = 32'h11; held_arg2 = 32'h22;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h00853020, 32'h33, 32'h44, 1'b0, 1'b0, 1'b0);
      check("stall_id_ready", 32'(id_ready), 32'd0);
      check("stall_arg1", ex_arg1, held_arg1);
      check("stall_arg2", ex_arg2, held_arg2);
    end
    step(1'b1, 32'h00853020, 32'h33, 32'h44, 1'b0, 1'b1, 1'b0);
    check("release_arg1", ex_arg1, 32'h33);
    check("release_wr_reg", 32'(ex_wr_reg), 32'd6);

    // Flush in the same cycle as a valid transfer.
    cnt_before = m_issue;
    step(1'b1, 32'h00221820, 32'd1, 32'd2, 1'b1, 1'b1, 1'b0);
    check("flush_ex_valid", 32'(ex_valid), 32'd0);
    check("flush_issue_cnt", 32'(issue_cnt), 32'(cnt_before));

    // Illegal opcode 0x3F.
    step(1'b1, 32'hFC221820, 32'd1, 32'd2, 1'b0, 1'b1, 1'b0);
    check("ill_flag", 32'(ex_illegal), 32'd1);
    check("ill_reg_write", 32'(ex_reg_write), 32'd0);
    check("ill_cnt", 32'(illegal_cnt), 32'd1);
    check("sat_issue_cnt", 32'(s_issue_cnt), 32'd3);

    // Reset in the middle of a stall.
    step(1'b1, 32'h00221820, 32'd1, 32'd2, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h00221820, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00221820, 32'd1, 32'd2, 1'b0, 1'b0, 1'b1);
    check("rst_stall_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_stall_issue_cnt", 32'(issue_cnt), 32'd0);
    check("rst_stall_illegal_cnt", 32'(illegal_cnt), 32'd0);
    check("rst_stall_id_ready", 32'(id_ready), 32'd1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom,
           $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
